bip_core_param: RTL

- Parametrised successor of the BIP control block plus datapath.
- Multi-cycle accumulator CPU: fetches from a synchronous program memory and executes the BIP instruction set (HLT, STR, LD, LDI, ADD, ADDI, SUB, SUBI) on a DATA_W accumulator.
- Data memory is accessed through a request/ack handshake, so wait-state memories are supported.
- Sits at the top of the processor subsystem, between program ROM and data RAM.

---
 rtl/bip_core_param.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/bip_core_param.sv
// -----------------------------------------------------------------------------
// bip_core_param
//
// Multi-cycle accumulator CPU for the BIP instruction set (HLT, STR, LD, LDI,
// ADD, ADDI, SUB, SUBI). Instructions come from a synchronous program ROM.
// Data memory is reached through a request/ack handshake, so slow memories
// can insert wait states.
//
// Instruction word: {opcode[4:0], operand[OPER_W-1:0]}, OPER_W = DATA_W-5.
// PA_W and DA_W must not exceed OPER_W.
//
// Optional build macro: BIP_BRANCH_EN adds BEQ (01000), BNE (01001) and
// JMP (01010). Without it those opcodes are undefined.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   prog_addr  program ROM address (current PC)
//   prog_data  instruction word, valid one cycle after prog_addr
//   dm_addr    data memory address (operand low bits)
//   dm_rd_en   read request, held until dm_ack
//   dm_wr_en   write request, held until dm_ack
//   dm_wdata   write data (accumulator)
//   dm_rdata   read data, sampled in the dm_ack cycle
//   dm_ack     memory completion strobe
//   acc_out    accumulator
//   halted     high while in HALT
//   retire     one-cycle pulse per completed instruction
//   illegal    one-cycle pulse on an undefined opcode
// -----------------------------------------------------------------------------
module bip_core_param #(
  parameter int DATA_W = 16,
  parameter int PA_W   = 11,
  parameter int DA_W   = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [PA_W-1:0]   prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DA_W-1:0]   dm_addr,
  output logic              dm_rd_en,
  output logic              dm_wr_en,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic [DATA_W-1:0] acc_out,
  output logic              halted,
  output logic              retire,
  output logic              illegal
);

  localparam int OPER_W = DATA_W - 5;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STR  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_JMP  = 5'b01010
  } opcode_t;

  state_t            state, state_d;
  logic [PA_W-1:0]   pc, pc_d, pc_inc;
  logic [DATA_W-1:0] acc, acc_d;
  logic [DATA_W-1:0] ir, ir_d;
  logic              rd_d, wr_d, retire_d, illegal_d;
  logic [4:0]        opcode;
  logic [DATA_W-1:0] op_ext;

  assign opcode = ir[DATA_W-1 -: 5];
  assign op_ext = {{(DATA_W-OPER_W){ir[OPER_W-1]}}, ir[OPER_W-1:0]};
  // Natural PA_W-bit overflow gives the wrap from the top address to 0.
  assign pc_inc = pc + PA_W'(1);

  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    acc_d     = acc;
    ir_d      = ir;
    rd_d      = dm_rd_en;
    wr_d      = dm_wr_en;
    retire_d  = 1'b0;
    illegal_d = 1'b0;

    case (state)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        ir_d    = prog_data;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        case (opcode)
          OP_HLT: begin
            retire_d = 1'b1;
            state_d  = S_HALT;
          end
          OP_LDI, OP_ADDI, OP_SUBI: begin
            if (opcode == OP_LDI)       acc_d = op_ext;
            else if (opcode == OP_ADDI) acc_d = acc + op_ext;
            else                        acc_d = acc - op_ext;
            pc_d     = pc_inc;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          OP_STR: begin
            wr_d    = 1'b1;
            state_d = S_MEM;
          end
          OP_LD, OP_ADD, OP_SUB: begin
            rd_d    = 1'b1;
            state_d = S_MEM;
          end
`ifdef BIP_BRANCH_EN
          OP_BEQ, OP_BNE, OP_JMP: begin
            if ((opcode == OP_JMP) ||
                ((opcode == OP_BEQ) && (acc == '0)) ||
                ((opcode == OP_BNE) && (acc != '0)))
              pc_d = ir[PA_W-1:0];
            else
              pc_d = pc_inc;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
`endif
          default: begin
            // Undefined opcode behaves as a NOP that flags itself.
            illegal_d = 1'b1;
            pc_d      = pc_inc;
            retire_d  = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        // Strobe, address and write data stay put until the memory answers.
        if (dm_ack) begin
          case (opcode)
            OP_LD:   acc_d = dm_rdata;
            OP_ADD:  acc_d = acc + dm_rdata;
            OP_SUB:  acc_d = acc - dm_rdata;
            default: acc_d = acc;
          endcase
          pc_d     = pc_inc;
          retire_d = 1'b1;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          state_d  = S_FETCH;
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_FETCH;
      pc       <= '0;
      acc      <= '0;
      ir       <= '0;
      dm_rd_en <= 1'b0;
      dm_wr_en <= 1'b0;
      retire   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      acc      <= acc_d;
      ir       <= ir_d;
      dm_rd_en <= rd_d;
      dm_wr_en <= wr_d;
      retire   <= retire_d;
      illegal  <= illegal_d;
    end
  end

  assign prog_addr = pc;
  assign dm_addr   = ir[DA_W-1:0];
  assign dm_wdata  = acc;
  assign acc_out   = acc;
  assign halted    = (state == S_HALT);

endmodule
